// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter slice.
// Optional feature macro: RR_ARB_TIMEOUT_EN (bounded tenure). Default build leaves it undefined:
// `define RR_ARB_TIMEOUT_EN
package rr_arbiter_pkg;

   // Default arbiter sizing
   localparam int unsigned RR_N_DEFAULT        = 4;
   localparam int unsigned RR_HOLD_MAX_DEFAULT = 8;

   // Arbiter occupancy; derived from the grant register, never stored separately
   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OWNED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority encoder: first set bit of cand scanning ptr, ptr+1 .. N-1, 0 .. ptr-1.
module rr_priority_pick import rr_arbiter_pkg::*; #(
   parameter  int unsigned N    = RR_N_DEFAULT,
   localparam int unsigned IDXW = $clog2(N)
) (
   input  logic [N-1:0]    cand,
   input  logic [IDXW-1:0] ptr,
   output logic [N-1:0]    onehot,
   output logic [IDXW-1:0] idx,
   output logic            any
);

   // Scan from the pointer with wrap-around; the first hit wins
   always_comb begin
      int unsigned     j;
      logic [IDXW-1:0] j_idx;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         j     = (32'(ptr) + k) % N;
         j_idx = IDXW'(j);
         if (!any && cand[j_idx]) begin
            any           = 1'b1;
            idx           = j_idx;
            onehot[j_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant, rotating priority pointer, owner keeps the grant
// while its request stays high. Optional bounded tenure under macro RR_ARB_TIMEOUT_EN.
module rr_arbiter import rr_arbiter_pkg::*; #(
   parameter  int unsigned N        = RR_N_DEFAULT,
   parameter  int unsigned HOLD_MAX = RR_HOLD_MAX_DEFAULT,
   localparam int unsigned IDXW     = $clog2(N)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    grant,
   output logic [IDXW-1:0] grant_idx,
   output logic            busy
);

   logic [N-1:0]    grant_q, grant_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [N-1:0]    cand;
   logic [N-1:0]    pick_onehot;
   logic [IDXW-1:0] pick_idx;
   logic            pick_any;
   logic            owner_req;
   logic            others_req;
   logic            preempt;
   logic            keep;
   arb_state_e      state;

`ifdef RR_ARB_TIMEOUT_EN
   localparam int unsigned HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   logic [HW-1:0] hold_q, hold_d;
   logic          at_limit;
`else
   logic cfg_unused;
   assign cfg_unused = ^HOLD_MAX;
`endif

   // Occupancy and request summary relative to the current owner
   always_comb begin
      state      = (|grant_q) ? ARB_OWNED : ARB_IDLE;
      owner_req  = |(req & grant_q);
      others_req = |(req & ~grant_q);
   end

`ifdef RR_ARB_TIMEOUT_EN
   // Tenure limit: preempt only when someone else is actually waiting
   always_comb begin
      at_limit = (state == ARB_OWNED) && (hold_q == HW'(HOLD_MAX - 1));
      preempt  = at_limit && others_req;
   end
`else
   // Unbounded tenure
   always_comb begin
      preempt = 1'b0;
   end
`endif

   // Candidate set: the owner is excluded when it is being preempted
   always_comb begin
      keep = (state == ARB_OWNED) && owner_req && !preempt;
      cand = preempt ? (req & ~grant_q) : req;
   end

   rr_priority_pick #(.N(N)) u_pick (
      .cand   (cand),
      .ptr    (ptr_q),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   // Keep/pick mux: next grant, pointer and tenure counter
   always_comb begin
      grant_d = grant_q;
      ptr_d   = ptr_q;
`ifdef RR_ARB_TIMEOUT_EN
      hold_d  = hold_q;
`endif
      if (keep) begin
`ifdef RR_ARB_TIMEOUT_EN
         // Sole requester at the limit keeps the grant and starts a fresh window
         if (at_limit) begin
            hold_d = '0;
         end else if (hold_q != '1) begin
            hold_d = hold_q + 1'b1;
         end
`endif
      end else if (pick_any) begin
         grant_d = pick_onehot;
         ptr_d   = (pick_idx == IDXW'(N - 1)) ? '0 : pick_idx + 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
         hold_d  = '0;
`endif
      end else begin
         grant_d = '0;
      end
   end

   // State registers; reset overrides en, en=0 freezes everything
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_q <= '0;
         ptr_q   <= '0;
`ifdef RR_ARB_TIMEOUT_EN
         hold_q  <= '0;
`endif
      end else if (en) begin
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
`ifdef RR_ARB_TIMEOUT_EN
         hold_q  <= hold_d;
`endif
      end
   end

   // Outputs decoded straight from the grant register
   always_comb begin
      grant     = grant_q;
      busy      = |grant_q;
      grant_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant_q[i]) begin
            grant_idx = grant_idx | IDXW'(i);
         end
      end
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: reference model feeds a scoreboard queue, plus directed checks.
// Timeout scenarios are exercised when RR_ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter;

   localparam int unsigned N        = 4;
   localparam int unsigned HOLD_MAX = 8;
   localparam int unsigned IDXW     = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic            en;
   logic [N-1:0]    req;
   logic [N-1:0]    grant;
   logic [IDXW-1:0] grant_idx;
   logic            busy;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model state
   logic [N-1:0] m_grant = '0;
   int unsigned  m_ptr   = 0;
   int unsigned  m_hold  = 0;
   logic [N-1:0] exp_q[$];

   rr_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .req       (req),
      .grant     (grant),
      .grant_idx (grant_idx),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] onehot_to_idx(input logic [N-1:0] g);
      logic [31:0] r;
      r = 0;
      for (int i = 0; i < N; i++) if (g[i]) r = i;
      return r;
   endfunction

   // Behavioural next-state of the arbiter for the inputs currently driven
   task automatic model_step();
      int     owner;
      logic   pre;
      logic   found;
      logic [N-1:0] c;
      owner = -1;
      for (int i = 0; i < N; i++) if (m_grant[i]) owner = i;
      if (reset) begin
         m_grant = '0; m_ptr = 0; m_hold = 0;
      end else if (en) begin
         pre = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
         pre = (owner >= 0) && (m_hold == HOLD_MAX - 1) && ((req & ~m_grant) != '0);
`endif
         if (owner >= 0 && req[owner] && !pre) begin
            m_hold = (m_hold == HOLD_MAX - 1) ? 0 : m_hold + 1;
         end else begin
            c = pre ? (req & ~m_grant) : req;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
               int j;
               j = (m_ptr + k) % N;
               if (!found && c[j]) begin
                  found = 1'b1;
                  m_grant = '0;
                  m_grant[j] = 1'b1;
                  m_ptr = (j + 1) % N;
                  m_hold = 0;
               end
            end
            if (!found) m_grant = '0;
         end
      end
      exp_q.push_back(m_grant);
   endtask

   // Drive one cycle, then compare the DUT against the oldest scoreboard entry
   task automatic step(input logic [N-1:0] r, input logic e, input logic rs);
      logic [N-1:0] exp_g;
      req = r; en = e; reset = rs;
      model_step();
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         exp_g = exp_q.pop_front();
         check("sb_grant", 32'(grant), 32'(exp_g));
         check("sb_idx", 32'(grant_idx), onehot_to_idx(exp_g));
         check("sb_busy", 32'(busy), 32'(|exp_g));
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; req = 4'b1111;

      // 1 Reset with all requesting, then first grant to requester 0
      step(4'b1111, 1'b1, 1'b1);
      step(4'b1111, 1'b1, 1'b1);
      check("t1_rst_grant", 32'(grant), 32'h0);
      check("t1_rst_busy", 32'(busy), 32'h0);
      check("t1_rst_idx", 32'(grant_idx), 32'h0);
      step(4'b1111, 1'b1, 1'b0);
      check("t1_first", 32'(grant), 32'b0001);
      step(4'b0000, 1'b1, 1'b0);
      check("t1_idle", 32'(grant), 32'h0);

      // 2 Single requester
      step(4'b0100, 1'b1, 1'b0);
      check("t2_grant", 32'(grant), 32'b0100);
      check("t2_idx", 32'(grant_idx), 32'd2);
      for (int i = 0; i < 5; i++) begin
         step(4'b0100, 1'b1, 1'b0);
         check("t2_hold", 32'(grant), 32'b0100);
      end
      step(4'b0000, 1'b1, 1'b0);
      check("t2_drop", 32'(grant), 32'h0);

      // 3 Rotation with back-to-back handoff
      step(4'b0000, 1'b1, 1'b1);
      step(4'b1111, 1'b1, 1'b0);
      check("t3_g0", 32'(grant), 32'b0001);
      step(4'b1110, 1'b1, 1'b0);
      check("t3_g1", 32'(grant), 32'b0010);
      step(4'b1101, 1'b1, 1'b0);
      check("t3_g2", 32'(grant), 32'b0100);
      step(4'b1011, 1'b1, 1'b0);
      check("t3_g3", 32'(grant), 32'b1000);
      step(4'b0111, 1'b1, 1'b0);
      check("t3_g0b", 32'(grant), 32'b0001);

      // 4 Pointer wrap after owner 3
      step(4'b0000, 1'b1, 1'b0);
      step(4'b1000, 1'b1, 1'b0);
      check("t4_own3", 32'(grant), 32'b1000);
      step(4'b1101, 1'b1, 1'b0);
      check("t4_keep3", 32'(grant), 32'b1000);
      step(4'b0101, 1'b1, 1'b0);
      check("t4_wrap", 32'(grant), 32'b0001);
      step(4'b0100, 1'b1, 1'b0);
      check("t4_next", 32'(grant), 32'b0100);

      // 5 Freeze, then reset mid-tenure
      step(4'b0000, 1'b0, 1'b0);
      check("t5_frz0", 32'(grant), 32'b0100);
      step(4'b0011, 1'b0, 1'b0);
      check("t5_frz1", 32'(grant), 32'b0100);
      step(4'b0000, 1'b1, 1'b0);
      check("t5_thaw", 32'(grant), 32'h0);
      step(4'b0010, 1'b1, 1'b0);
      check("t5_own1", 32'(grant), 32'b0010);
      step(4'b0010, 1'b0, 1'b1);
      check("t5_rst", 32'(grant), 32'h0);
      step(4'b0011, 1'b1, 1'b0);
      check("t5_after", 32'(grant), 32'b0001);

      // 6 Tenure: bounded with the timeout feature, unbounded otherwise
      step(4'b0000, 1'b1, 1'b1);
`ifdef RR_ARB_TIMEOUT_EN
      for (int i = 0; i < 8; i++) begin
         step(4'b0011, 1'b1, 1'b0);
         check("t6_own0", 32'(grant), 32'b0001);
      end
      for (int i = 0; i < 8; i++) begin
         step(4'b0011, 1'b1, 1'b0);
         check("t6_own1", 32'(grant), 32'b0010);
      end
      step(4'b0011, 1'b1, 1'b0);
      check("t6_back0", 32'(grant), 32'b0001);
      step(4'b0000, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(4'b0001, 1'b1, 1'b0);
         check("t6_solo", 32'(grant), 32'b0001);
      end
`else
      for (int i = 0; i < 20; i++) begin
         step(4'b0011, 1'b1, 1'b0);
         check("t6_unbounded", 32'(grant), 32'b0001);
      end
`endif

      // Random traffic against the model
      for (int i = 0; i < 300; i++) begin
         step(4'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
